keypad_scanner: RTL and testbench

//  Scans a 4x4 matrix keypad on the GPIO header. The input-side companion to the time-multiplexed

---
 rtl/keypad_pkg.sv | 37 +++
 rtl/keypad_sync.sv | 24 ++
 rtl/keypad_scanner.sv | 169 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared state encoding, key-code type, idle/reset constants and small helpers
// for the 4x4 keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      DEB_PRESS,
      PRESSED,
      DEB_REL
   } kp_state_t;

   typedef logic [3:0] key_code_t;

   localparam logic [3:0] IDLE_COLS = 4'hF;
   localparam logic [3:0] ROW_RESET = 4'b1110;

   // Index of the lowest-numbered low bit; 0 when no bit is low.
   function automatic logic [1:0] lowest_low(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (!v[3 - i]) idx = 2'(3 - i);
      end
      return idx;
   endfunction

   // Counter width able to hold the largest of the three tick counts.
   function automatic int unsigned cnt_width(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/keypad_sync.sv
// Parameterised-width two-flop synchroniser for the asynchronous keypad columns;
// resets to all ones (idle, pulled-up columns).
module keypad_sync #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (!rst) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row walk, per-press debounce, sticky valid/ack key
// handshake with overrun flag. Define KEYPAD_REPEAT_EN to build auto-repeat.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV_W   = 16,
   parameter int unsigned DEBOUNCE_N   = 4,
   parameter int unsigned REPEAT_DELAY = 64,
   parameter int unsigned REPEAT_RATE  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col_in,
   output logic [3:0] row_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ack,
   output logic       key_down,
   output logic       overrun
);

   // One tick counter serves both debounce and (optionally) repeat timing.
   localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_N, REPEAT_DELAY, REPEAT_RATE);
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_N);

   logic [SCAN_DIV_W-1:0] presc;
   logic                  tick;
   logic [3:0]            cols_s;
   kp_state_t             state, state_n;
   logic [3:0]            row_n;
   logic [3:0]            pat, pat_n;
   logic [CNT_W-1:0]      cnt, cnt_n, cnt_inc;
   key_code_t             key_lat, key_lat_n;
   logic                  accept;

`ifdef KEYPAD_REPEAT_EN
   localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_RATE);
   logic rpt_seen, rpt_seen_n;
`endif

   keypad_sync #(.WIDTH(4)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (col_in),
      .q   (cols_s)
   );

   always_ff @(posedge clk) begin
      if (!rst) presc <= '0;
      else      presc <= presc + 1'b1;
   end

   assign tick     = &presc;
   assign cnt_inc  = cnt + 1'b1;
   assign key_down = (state == PRESSED) || (state == DEB_REL);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= SCAN;
         row_out <= ROW_RESET;
         cnt     <= '0;
         pat     <= IDLE_COLS;
         key_lat <= '0;
      end else begin
         state   <= state_n;
         row_out <= row_n;
         cnt     <= cnt_n;
         pat     <= pat_n;
         key_lat <= key_lat_n;
      end
   end

`ifdef KEYPAD_REPEAT_EN
   always_ff @(posedge clk) begin
      if (!rst) rpt_seen <= 1'b0;
      else      rpt_seen <= rpt_seen_n;
   end
`endif

   always_comb begin
      state_n   = state;
      row_n     = row_out;
      cnt_n     = cnt;
      pat_n     = pat;
      key_lat_n = key_lat;
      accept    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_seen_n = rpt_seen;
`endif
      if (tick) begin
         unique case (state)
            SCAN: begin
               if (cols_s != IDLE_COLS) begin
                  state_n   = DEB_PRESS;
                  cnt_n     = CNT_W'(1);
                  pat_n     = cols_s;
                  key_lat_n = {lowest_low(row_out), lowest_low(cols_s)};
               end else begin
                  row_n = {row_out[2:0], row_out[3]};
               end
            end
            DEB_PRESS: begin
               // A mismatch drops back to SCAN on the same row: no rotation this tick.
               if (cols_s != pat) begin
                  state_n = SCAN;
                  cnt_n   = '0;
               end else if (cnt_inc == DEB_LAST) begin
                  state_n = PRESSED;
                  cnt_n   = '0;
                  accept  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                  rpt_seen_n = 1'b0;
`endif
               end else begin
                  cnt_n = cnt_inc;
               end
            end
            PRESSED: begin
               if (cols_s == IDLE_COLS) begin
                  state_n = DEB_REL;
                  cnt_n   = CNT_W'(1);
`ifdef KEYPAD_REPEAT_EN
                  rpt_seen_n = 1'b0;
               end else if (cnt_inc == (rpt_seen ? RPT_NEXT : RPT_FIRST)) begin
                  cnt_n      = '0;
                  rpt_seen_n = 1'b1;
                  accept     = 1'b1;
               end else begin
                  cnt_n = cnt_inc;
`endif
               end
            end
            DEB_REL: begin
               if (cols_s != IDLE_COLS) begin
                  state_n = PRESSED;
                  cnt_n   = '0;
               end else if (cnt_inc == DEB_LAST) begin
                  state_n = SCAN;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt_inc;
               end
            end
         endcase
      end
   end

   // An ack coinciding with an accept consumes the old key, so the new one replaces it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         key_code  <= '0;
         key_valid <= 1'b0;
         overrun   <= 1'b0;
      end else if (accept) begin
         if (!key_valid || key_ack) begin
            key_code  <= key_lat;
            key_valid <= 1'b1;
            overrun   <= 1'b0;
         end else begin
            overrun <= 1'b1;
         end
      end else if (key_ack && key_valid) begin
         key_valid <= 1'b0;
         overrun   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: tick-level behavioural keypad/scanner model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_keypad_scanner;

   localparam int DEB = 4;
   localparam int RD  = 8;
   localparam int RR  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        key_ack = 1'b0;
   logic [15:0] pressed = '0;
   logic [3:0]  col_in;
   logic [3:0]  row_out;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_down;
   logic        overrun;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state (tick-level counters, not a state machine copy)
   int         m_presc = 0;
   int         m_row = 0;
   int         m_run = 0;
   int         m_hold = 0;
   int         m_reps = 0;
   int         m_key = 0;
   int         m_ticks = 0;
   logic       m_held = 1'b0;
   logic       m_init = 1'b0;
   logic       m_acc;
   logic [3:0] m_s1 = 4'hF;
   logic [3:0] m_s2 = 4'hF;
   logic [3:0] m_cand = 4'hF;
   logic [3:0] m_rv;
   logic [3:0] m_cin;
   logic [3:0] e_code = 4'h0;
   logic       e_valid = 1'b0;
   logic       e_over = 1'b0;
   logic [3:0] e_row;

   keypad_scanner #(
      .SCAN_DIV_W   (3),
      .DEBOUNCE_N   (DEB),
      .REPEAT_DELAY (RD),
      .REPEAT_RATE  (RR)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .col_in    (col_in),
      .row_out   (row_out),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_ack   (key_ack),
      .key_down  (key_down),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   // Physical matrix: a column reads low when a pressed key sits on a driven row.
   function automatic logic [3:0] keypad_cols(input logic [3:0] rows, input logic [15:0] keys);
      logic [3:0] c;
      c = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 4; k++)
            if (rows[r] === 1'b0 && keys[r*4 + k]) c[k] = 1'b0;
      return c;
   endfunction

   function automatic int low_col(input logic [3:0] v);
      int r;
      r = 0;
      for (int k = 3; k >= 0; k--) if (!v[k]) r = k;
      return r;
   endfunction

   assign col_in = keypad_cols(row_out, pressed);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model steps on each rising edge; DUT outputs compared on the falling edge.
   always begin
      @(posedge clk);
      if (rst !== 1'b1) begin
         m_presc = 0; m_row = 0; m_run = 0; m_hold = 0; m_reps = 0; m_key = 0;
         m_held = 1'b0; m_s1 = 4'hF; m_s2 = 4'hF; m_cand = 4'hF;
         e_code = 4'h0; e_valid = 1'b0; e_over = 1'b0; m_init = 1'b1;
      end else begin
         m_rv  = ~(4'b0001 << m_row);
         m_cin = keypad_cols(m_rv, pressed);
         m_acc = 1'b0;
         if (m_presc == 7) begin
            m_ticks++;
            if (!m_held) begin
               if (m_run == 0) begin
                  if (m_s2 != 4'hF) begin
                     m_cand = m_s2;
                     m_key  = m_row * 4 + low_col(m_s2);
                     m_run  = 1;
                  end else begin
                     m_row = (m_row + 1) % 4;
                  end
               end else if (m_s2 == m_cand) begin
                  m_run++;
                  if (m_run == DEB) begin
                     m_acc = 1'b1; m_held = 1'b1; m_run = 0; m_hold = 0; m_reps = 0;
                  end
               end else begin
                  m_run = 0;
               end
            end else if (m_s2 == 4'hF) begin
               m_run++; m_hold = 0; m_reps = 0;
               if (m_run == DEB) begin
                  m_held = 1'b0; m_run = 0;
               end
            end else if (m_run != 0) begin
               m_run = 0;
            end else begin
`ifdef KEYPAD_REPEAT_EN
               m_hold++;
               if (m_hold == ((m_reps == 0) ? RD : RR)) begin
                  m_acc = 1'b1; m_hold = 0; m_reps++;
               end
`endif
            end
         end
         m_presc = (m_presc + 1) % 8;
         m_s2 = m_s1;
         m_s1 = m_cin;
         if (m_acc) begin
            if (!e_valid || key_ack) begin
               e_code = 4'(m_key); e_valid = 1'b1; e_over = 1'b0;
            end else begin
               e_over = 1'b1;
            end
         end else if (key_ack && e_valid) begin
            e_valid = 1'b0; e_over = 1'b0;
         end
      end
      @(negedge clk);
      if (m_init) begin
         e_row = ~(4'b0001 << m_row);
         check("row_out", row_out, e_row);
         check("key_code", key_code, e_code);
         check("key_valid", key_valid, e_valid);
         check("key_down", key_down, m_held);
         check("overrun", overrun, e_over);
      end
   end

   function automatic bit cond(input int sel);
      case (sel)
         0: return key_valid === 1'b1;
         1: return key_down === 1'b1;
         2: return key_down === 1'b0;
         3: return row_out === 4'b1110;
         4: return row_out !== 4'b1110;
         5: return !m_held && m_run == DEB - 1 && m_presc == 7;
         6: return !m_held && m_run == 2;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_for(input int sel, input string name);
      int n;
      n = 0;
      while (!cond(sel) && n < 600) begin
         @(negedge clk);
         n++;
      end
      if (!cond(sel)) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout %s: condition not reached, waited %0d cycles", name, n);
      end
   endtask

   task automatic wait_ticks(input int n);
      int target;
      int guard;
      target = m_ticks + n;
      guard  = 0;
      while (m_ticks < target && guard < 8 * n + 16) begin
         @(negedge clk);
         guard++;
      end
   endtask

   initial begin
      int accepts;
      int exp_accepts;

      // 1: reset values and idle row walk
      repeat (3) @(negedge clk);
      check("rst_row", row_out, 4'b1110);
      check("rst_valid", key_valid, 1'b0);
      check("rst_code", key_code, 4'h0);
      check("rst_down", key_down, 1'b0);
      check("rst_over", overrun, 1'b0);
      rst = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         @(negedge clk);
         if (i == 7)  check("walk_7", row_out, 4'b1110);
         if (i == 8)  check("walk_8", row_out, 4'b1101);
         if (i == 16) check("walk_16", row_out, 4'b1011);
         if (i == 24) check("walk_24", row_out, 4'b0111);
         if (i == 32) check("walk_32", row_out, 4'b1110);
      end

      // 2: key 9 (row 2, col 1)
      pressed[9] = 1'b1;
      wait_for(0, "key9_valid");
      check("key9_code", key_code, 4'd9);
      check("key9_down", key_down, 1'b1);
      check("key9_row", row_out, 4'b1011);
      repeat (40) @(negedge clk);
      check("key9_frozen", row_out, 4'b1011);
      key_ack = 1'b1;
      @(negedge clk);
      key_ack = 1'b0;
      check("key9_acked", key_valid, 1'b0);
      pressed[9] = 1'b0;
      wait_for(2, "key9_release");

      // 3: bounce on key 0
      wait_for(4, "leave_row0");
      wait_for(3, "reach_row0");
      pressed[0] = 1'b1;
      wait_ticks(2);
      pressed[0] = 1'b0;
      wait_ticks(1);
      check("glitch_no_accept", key_valid, 1'b0);
      check("glitch_no_rotate", row_out, 4'b1110);
      pressed[0] = 1'b1;
      wait_ticks(4);
      check("bounce_accept", key_valid, 1'b1);
      check("bounce_code", key_code, 4'd0);

      // 4: overrun, then ack coincident with accept
      pressed[0] = 1'b0;
      wait_for(2, "key0_release");
      pressed[6] = 1'b1;
      wait_for(1, "key6_down");
      check("ovr_set", overrun, 1'b1);
      check("ovr_code_kept", key_code, 4'd0);
      check("ovr_valid", key_valid, 1'b1);
      pressed[6] = 1'b0;
      wait_for(2, "key6_release");
      pressed[15] = 1'b1;
      wait_for(5, "key15_last_deb");
      key_ack = 1'b1;
      @(negedge clk);
      key_ack = 1'b0;
      check("coinc_code", key_code, 4'd15);
      check("coinc_valid", key_valid, 1'b1);
      check("coinc_over", overrun, 1'b0);
      pressed[15] = 1'b0;
      wait_for(2, "key15_release");
      key_ack = 1'b1;
      @(negedge clk);
      key_ack = 1'b0;

      // 5: reset mid press-debounce
      pressed[5] = 1'b1;
      wait_for(6, "key5_mid_deb");
      rst = 1'b0;
      @(negedge clk);
      check("midrst_row", row_out, 4'b1110);
      check("midrst_valid", key_valid, 1'b0);
      check("midrst_code", key_code, 4'h0);
      check("midrst_down", key_down, 1'b0);
      check("midrst_over", overrun, 1'b0);
      rst = 1'b1;
      pressed[5] = 1'b0;

      // 6: hold key 0, acking every accept
      pressed[0] = 1'b1;
      wait_for(0, "hold_first");
      accepts = 1;
      key_ack = 1'b1;
      for (int i = 0; i < 176; i++) begin
         @(negedge clk);
         if (key_valid === 1'b1) begin
            accepts++;
            key_ack = 1'b1;
         end else begin
            key_ack = 1'b0;
         end
      end
      key_ack = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      exp_accepts = 5;
`else
      exp_accepts = 1;
`endif
      check("hold_accepts", accepts, exp_accepts);
      pressed[0] = 1'b0;
      wait_for(2, "hold_release");

      // Random traffic against the model
      for (int i = 0; i < 2500; i++) begin
         int k;
         @(negedge clk);
         key_ack = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 39) == 0) begin
            k = $urandom_range(0, 15);
            pressed[k] = ~pressed[k];
            if ($countones(pressed) > 2) pressed = '0;
         end
         rst = ($urandom_range(0, 1499) == 0) ? 1'b0 : 1'b1;
      end
      rst = 1'b1;
      key_ack = 1'b0;
      pressed = '0;
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
